// File: rtl/spi_prog_decoder.sv
// Loader protocol decoder: turns the SPI byte stream (0x01 + 4 address bytes,
// 0x02 + 4 data bytes, MSB first) into 32-bit memory writes over valid/ready.
module spi_prog_decoder #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_INC   = 4,
  parameter logic [7:0]  CMD_ADDR   = 8'h01,
  parameter logic [7:0]  CMD_DATA   = 8'h02
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic                  frame_end,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  overrun,
  output logic                  bad_cmd,
  input  logic                  status_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_cnt;
  logic [DATA_WIDTH-9:0]   r_shift;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wr_valid;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_overrun;
  logic                    r_bad_cmd;

  logic                    w_shift_en;
  logic                    w_last_byte;
  logic                    w_addr_done;
  logic                    w_word_done;
  logic                    w_bad_op;
  logic                    w_accept;
  logic                    w_buf_free;
  logic [DATA_WIDTH-1:0]   w_word;

  // Shift register plus the incoming byte forms the completed word on the 4th byte
  assign w_word     = {r_shift, rx_byte};
  assign w_accept   = r_wr_valid && wr_ready;
  assign w_buf_free = !r_wr_valid || w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A completing 4th byte is decoded before frame_end forces the abort
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_ADDR) begin
            w_next = S_ADDR;
          end else if (rx_byte == CMD_DATA) begin
            w_next = S_DATA;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_valid && (r_cnt == 2'd3)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (frame_end) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    w_shift_en  = 1'b0;
    w_last_byte = 1'b0;
    w_addr_done = 1'b0;
    w_word_done = 1'b0;
    w_bad_op    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_bad_op = rx_valid && (rx_byte != CMD_ADDR) && (rx_byte != CMD_DATA);
      end
      S_ADDR: begin
        w_shift_en  = rx_valid;
        w_last_byte = rx_valid && (r_cnt == 2'd3);
        w_addr_done = w_last_byte;
      end
      S_DATA: begin
        w_shift_en  = rx_valid;
        w_last_byte = rx_valid && (r_cnt == 2'd3);
        w_word_done = w_last_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 2'd0;
    end else if (frame_end || (r_state == S_IDLE)) begin
      r_cnt <= 2'd0;
    end else if (rx_valid) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[DATA_WIDTH-17:0], rx_byte};
    end
  end

  // Address advances on every completed data word, whether stored or dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_addr_done) begin
      r_addr <= w_word[ADDR_WIDTH-1:0];
    end else if (w_word_done) begin
      r_addr <= r_addr + ADDR_WIDTH'(ADDR_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (w_word_done && w_buf_free) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= r_addr;
      r_wr_data  <= w_word;
    end else if (w_accept) begin
      r_wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_bad_cmd <= 1'b0;
    end else if (status_clr) begin
      r_overrun <= 1'b0;
      r_bad_cmd <= 1'b0;
    end else begin
      if (w_word_done && !w_buf_free) begin
        r_overrun <= 1'b1;
      end
      if (w_bad_op) begin
        r_bad_cmd <= 1'b1;
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign overrun  = r_overrun;
  assign bad_cmd  = r_bad_cmd;
  assign busy     = (r_state != S_IDLE) || r_wr_valid;

endmodule
